deserializer: RTL and testbench

Receive-side counterpart of the team's 16-bit serializer. It rebuilds parallel words and their valid-bit counts from the serial bit/valid stream, MSB first, with the same `data_mod` encoding as the serializer. Completed words are buffered in a small output queue with a valid/ready handshake. Frames of illegal length and frames dropped because the queue is full are flagged.

---
 rtl/deserializer_if.sv | 36 +++
 rtl/deserializer.sv | 128 ++++++++++++
 tb/tb_deserializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/deserializer_if.sv
// ----------------------------------------------------------------------------
// deserializer_if
// Groups the serial input stream and the parallel output queue handshake of
// the deserializer.
//   ser_data_i / ser_data_val_i : serial bit stream, MSB first
//   data_o / data_mod_o         : queue-head word and its valid-bit count
//   data_val_o / data_ready_i   : output valid/ready handshake
//   busy_o                      : a frame is partially received
//   len_err_o / ovf_o           : one-cycle status pulses
// Modport slave is taken by the deserializer. Modport master is taken by
// the stream source and consumer.
// ----------------------------------------------------------------------------
interface deserializer_if #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
);
   logic              ser_data_i;
   logic              ser_data_val_i;
   logic [DATA_W-1:0] data_o;
   logic [MOD_W-1:0]  data_mod_o;
   logic              data_val_o;
   logic              data_ready_i;
   logic              busy_o;
   logic              len_err_o;
   logic              ovf_o;

   modport slave (
      input  ser_data_i, ser_data_val_i, data_ready_i,
      output data_o, data_mod_o, data_val_o, busy_o, len_err_o, ovf_o
   );

   modport master (
      output ser_data_i, ser_data_val_i, data_ready_i,
      input  data_o, data_mod_o, data_val_o, busy_o, len_err_o, ovf_o
   );
endinterface

// File: rtl/deserializer.sv
// ----------------------------------------------------------------------------
// deserializer
// Rebuilds parallel words (MSB first) and their valid-bit counts from a
// serial bit/valid stream. Completed frames go into a small FIFO that is
// read through a valid/ready handshake. A full DATA_W-bit frame is reported
// with data_mod_o = 0. Frames of 1 or 2 bits are discarded with a len_err_o
// pulse. Frames that arrive while the FIFO is full are dropped with an
// ovf_o pulse.
// Ports:
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-high reset
//   bus    : deserializer_if.slave (serial in, queue out, status pulses)
// ----------------------------------------------------------------------------
module deserializer #(
   parameter int DATA_W  = 16,
   parameter int MOD_W   = $clog2(DATA_W),
   parameter int Q_DEPTH = 2
) (
   input logic           clk_i,
   input logic           srst_i,
   deserializer_if.slave bus
);
   localparam int              QA_W     = $clog2(Q_DEPTH);
   localparam logic [MOD_W:0]  FULL_LEN = (MOD_W+1)'(DATA_W);
   localparam logic [MOD_W:0]  MIN_LEN  = (MOD_W+1)'(3);
   localparam logic [QA_W:0]   Q_FULL   = (QA_W+1)'(Q_DEPTH);

   typedef enum logic {IDLE, RECV} state_t;

   state_t            state_q, state_d;
   logic [MOD_W:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d, sh_nxt;
   logic [MOD_W-1:0]  bit_idx;
   logic              acc, close_full, close_idle, close_ev;
   logic [MOD_W:0]    frame_len;
   logic [DATA_W-1:0] word_in;

   logic              push, pop, wr_en, q_empty, q_full;
   logic              len_err_q, len_err_d, ovf_q, ovf_d;
   logic [QA_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [QA_W:0]     q_cnt_q, q_cnt_d;
   logic [DATA_W-1:0] mem_data_q [Q_DEPTH];
   logic [MOD_W-1:0]  mem_mod_q  [Q_DEPTH];

   // ---- assembly and frame close detection --------------------------------
   always_comb begin
      acc     = bus.ser_data_val_i;
      bit_idx = MOD_W'(DATA_W-1) - cnt_q[MOD_W-1:0];
      sh_nxt  = sh_q;
      if (acc) sh_nxt[bit_idx] = bus.ser_data_i;
      close_full = acc && ((cnt_q + (MOD_W+1)'(1)) == FULL_LEN);
      close_idle = !acc && (cnt_q != '0);
      close_ev   = close_full || close_idle;
      // A full frame closes on its last bit, so that bit must be merged in.
      frame_len  = close_full ? FULL_LEN : cnt_q;
      word_in    = close_full ? sh_nxt : sh_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_nxt;
      case (state_q)
         IDLE:    if (acc)      state_d = RECV;
         RECV:    if (close_ev) state_d = IDLE;
         default:               state_d = IDLE;
      endcase
      if (close_ev) begin
         cnt_d = '0;
         sh_d  = '0;
      end else if (acc) begin
         cnt_d = cnt_q + (MOD_W+1)'(1);
      end
   end

   // ---- output queue control ----------------------------------------------
   always_comb begin
      q_empty   = (q_cnt_q == '0);
      q_full    = (q_cnt_q == Q_FULL);
      pop       = !q_empty && bus.data_ready_i;
      push      = close_ev && (frame_len >= MIN_LEN);
      len_err_d = close_ev && (frame_len < MIN_LEN);
      // A pop in the same cycle frees the slot the push needs.
      wr_en     = push && (!q_full || pop);
      ovf_d     = push && q_full && !pop;
      q_cnt_d   = q_cnt_q;
      if (wr_en && !pop)      q_cnt_d = q_cnt_q + (QA_W+1)'(1);
      else if (!wr_en && pop) q_cnt_d = q_cnt_q - (QA_W+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         q_cnt_q   <= '0;
         len_err_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         q_cnt_q   <= q_cnt_d;
         len_err_q <= len_err_d;
         ovf_q     <= ovf_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + QA_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + QA_W'(1);
      end
   end

   // Storage needs no reset: the head outputs are gated by the queue count.
   always_ff @(posedge clk_i) begin
      if (wr_en && !srst_i) begin
         mem_data_q[wr_ptr_q] <= word_in;
         mem_mod_q[wr_ptr_q]  <= frame_len[MOD_W-1:0];
      end
   end

   // ---- head and status outputs -------------------------------------------
   assign bus.data_val_o = !q_empty;
   assign bus.data_o     = q_empty ? '0 : mem_data_q[rd_ptr_q];
   assign bus.data_mod_o = q_empty ? '0 : mem_mod_q[rd_ptr_q];
   assign bus.busy_o     = (state_q == RECV);
   assign bus.len_err_o  = len_err_q;
   assign bus.ovf_o      = ovf_q;
endmodule

// File: tb/tb_deserializer.sv
// ----------------------------------------------------------------------------
// tb_deserializer
// Table-driven bench for the deserializer. Each table row is one clock
// cycle: the inputs applied before the edge and the outputs required just
// after it. A hand-written sequence covers gapless full frames and a
// push/pop in the same cycle on a full queue.
// ----------------------------------------------------------------------------
module tb_deserializer;
   logic clk  = 1'b0;
   logic srst = 1'b1;

   deserializer_if #(.DATA_W(16)) bus ();

   deserializer #(.DATA_W(16), .Q_DEPTH(2)) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, sd, sv, rdy;
      logic        ev;
      logic [15:0] ed;
      logic [3:0]  em;
      logic        eb, el, eo;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input logic rst, input logic sd, input logic sv,
                      input logic rdy, input logic ev, input logic [15:0] ed,
                      input logic [3:0] em, input logic eb, input logic el,
                      input logic eo);
      vec_t v;
      v.rst = rst; v.sd = sd; v.sv = sv; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.em = em; v.eb = eb; v.el = el; v.eo = eo;
      tbl.push_back(v);
   endtask

   // Appends the first n bits of w (MSB first); the queue head is expected
   // to hold (hv, hd, hm) and the block to be busy after each bit.
   task automatic add_bits(input logic [15:0] w, input int n, input logic rdy,
                           input logic hv, input logic [15:0] hd,
                           input logic [3:0] hm);
      for (int k = 0; k < n; k++)
         add(1'b0, w[15-k], 1'b1, rdy, hv, hd, hm, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic step(input logic rst, input logic sd, input logic sv,
                       input logic rdy);
      srst               = rst;
      bus.ser_data_i     = sd;
      bus.ser_data_val_i = sv;
      bus.data_ready_i   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic ev,
                        input logic [15:0] ed, input logic [3:0] em,
                        input logic eb, input logic el, input logic eo);
      n_vec++;
      if (bus.data_val_o !== ev || bus.data_o !== ed || bus.data_mod_o !== em ||
          bus.busy_o !== eb || bus.len_err_o !== el || bus.ovf_o !== eo) begin
         n_err++;
         $display("FAIL %s: got val=%b data=%h mod=%0d busy=%b len_err=%b ovf=%b, want val=%b data=%h mod=%0d busy=%b len_err=%b ovf=%b",
                  name, bus.data_val_o, bus.data_o, bus.data_mod_o, bus.busy_o,
                  bus.len_err_o, bus.ovf_o, ev, ed, em, eb, el, eo);
      end
   endtask

   initial begin
      logic [15:0] w;
      bus.ser_data_i     = 1'b0;
      bus.ser_data_val_i = 1'b0;
      bus.data_ready_i   = 1'b0;

      // Reset with bits presented: they are ignored.
      add(1, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0);
      add(1, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      // Full-length frame 16'hDAAC.
      add_bits(16'hDAAC, 15, 1'b1, 1'b0, 16'h0, 4'd0);
      add(0, 0, 1, 1, 1, 16'hDAAC, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      // Short frame of five ones.
      add_bits(16'hF800, 5, 1'b1, 1'b0, 16'h0, 4'd0);
      add(0, 0, 0, 1, 1, 16'hF800, 5, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      // Illegal 2-bit frame, then a legal 3-bit frame 101.
      add_bits(16'h8000, 2, 1'b1, 1'b0, 16'h0, 4'd0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);
      add_bits(16'hA000, 3, 1'b1, 1'b0, 16'h0, 4'd0);
      add(0, 0, 0, 1, 1, 16'hA000, 3, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      // Backpressure: 111, 010 queued, 001 dropped with ovf.
      add_bits(16'hE000, 3, 1'b0, 1'b0, 16'h0, 4'd0);
      add(0, 0, 0, 0, 1, 16'hE000, 3, 0, 0, 0);
      add_bits(16'h4000, 3, 1'b0, 1'b1, 16'hE000, 4'd3);
      add(0, 0, 0, 0, 1, 16'hE000, 3, 0, 0, 0);
      add_bits(16'h2000, 3, 1'b0, 1'b1, 16'hE000, 4'd3);
      add(0, 0, 0, 0, 1, 16'hE000, 3, 0, 0, 1);
      add(0, 0, 0, 1, 1, 16'h4000, 3, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      // Reset after 7 bits, then a clean 16'h1234 frame.
      add_bits(16'hFE00, 7, 1'b1, 1'b0, 16'h0, 4'd0);
      add(1, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);
      add_bits(16'h1234, 15, 1'b1, 1'b0, 16'h0, 4'd0);
      add(0, 0, 1, 1, 1, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].sd, tbl[i].sv, tbl[i].rdy);
         check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].em,
               tbl[i].eb, tbl[i].el, tbl[i].eo);
      end

      // Gapless full frames 16'hFFFF then 16'h0001.
      w = 16'hFFFF;
      for (int k = 0; k < 15; k++) begin
         step(0, w[15-k], 1, 1);
         check("gap_a_bit", 0, 16'h0, 0, 1, 0, 0);
      end
      step(0, w[0], 1, 1);
      check("gap_a_word", 1, 16'hFFFF, 0, 0, 0, 0);
      w = 16'h0001;
      for (int k = 0; k < 15; k++) begin
         step(0, w[15-k], 1, 1);
         check("gap_b_bit", 0, 16'h0, 0, 1, 0, 0);
      end
      step(0, w[0], 1, 1);
      check("gap_b_word", 1, 16'h0001, 0, 0, 0, 0);
      step(0, 0, 0, 1);
      check("gap_drain", 0, 16'h0, 0, 0, 0, 0);

      // Fill the queue with E000, C000; push A000 while popping.
      w = 16'hE000;
      for (int k = 0; k < 3; k++) begin
         step(0, w[15-k], 1, 0);
         check("pp_a_bit", 0, 16'h0, 0, 1, 0, 0);
      end
      step(0, 0, 0, 0);
      check("pp_a_word", 1, 16'hE000, 3, 0, 0, 0);
      w = 16'hC000;
      for (int k = 0; k < 3; k++) begin
         step(0, w[15-k], 1, 0);
         check("pp_b_bit", 1, 16'hE000, 3, 1, 0, 0);
      end
      step(0, 0, 0, 0);
      check("pp_full", 1, 16'hE000, 3, 0, 0, 0);
      w = 16'hA000;
      for (int k = 0; k < 3; k++) begin
         step(0, w[15-k], 1, 0);
         check("pp_c_bit", 1, 16'hE000, 3, 1, 0, 0);
      end
      step(0, 0, 0, 1);
      check("pp_push_pop", 1, 16'hC000, 3, 0, 0, 0);
      step(0, 0, 0, 1);
      check("pp_pop_c", 1, 16'hA000, 3, 0, 0, 0);
      step(0, 0, 0, 1);
      check("pp_empty", 0, 16'h0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
